// File: rtl/ram_ctrl_pkg.sv
// Shared constants and types for the ram32x4 controller/arbiter.
package ram_ctrl_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  // Controller mode: wiping the RAM, or serving the two requesters.
  typedef enum logic {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } state_t;

  // Bit positions of the two requesters in req/gnt vectors.
  localparam int PORT_A = 0;
  localparam int PORT_B = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. A lone requester always wins and leaves
// the pointer alone; on contention the pointer's port wins and the pointer
// moves to the other port.
module rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr;

  // Grant selection: pass a single request straight through, split ties by ptr.
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt[ptr] = 1'b1;
    end else begin
      gnt = req;
    end
  end

  // Pointer moves only when both ports competed this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= 1'(PORT_A);
    end else if (req == 2'b11) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/ram32x4_arbiter.sv
// Owner of the single ram32x4 port: wipes all words after reset or on request,
// then shares the port between requesters A and B with round-robin grants.
module ram32x4_arbiter
#(
  parameter int ADDR_W = ram_ctrl_pkg::ADDR_W,
  parameter int DATA_W = ram_ctrl_pkg::DATA_W
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              init_done,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  import ram_ctrl_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_d;
  logic              done_d, wren_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;
  logic [1:0]        elig, arb_req, arb_gnt, rd_d;
  logic [1:0]        rd_vld_p0, rd_vld_p1;

  // A port may not be granted in the cycle right after its own grant.
  assign elig    = {b_req & ~b_gnt, a_req & ~a_gnt};
  assign arb_req = (state_q == SERVE && !clr_req) ? elig : 2'b00;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (arb_req),
    .gnt   (arb_gnt)
  );

  // Next-state and next-command logic for the clear/serve controller.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt;
    done_d    = init_done;
    wren_d    = 1'b0;
    addr_d    = ram_addr;
    data_d    = ram_data;
    rd_d      = 2'b00;
    case (state_q)
      CLEAR: begin
        // The clear write to the last word is on the RAM bus exactly when it
        // shows wren with LAST_ADDR; entry into CLEAR always starts with wren low.
        if (ram_wren && ram_addr == LAST_ADDR) begin
          state_d   = SERVE;
          done_d    = 1'b1;
          clr_cnt_d = '0;
        end else begin
          wren_d = 1'b1;
          addr_d = clr_cnt;
          data_d = '0;
          if (clr_cnt != LAST_ADDR) begin
            clr_cnt_d = clr_cnt + 1'b1;
          end
        end
      end
      SERVE: begin
        if (clr_req) begin
          state_d   = CLEAR;
          done_d    = 1'b0;
          clr_cnt_d = '0;
        end else if (arb_gnt[PORT_A]) begin
          wren_d       = a_we;
          addr_d       = a_addr;
          data_d       = a_wdata;
          rd_d[PORT_A] = ~a_we;
        end else if (arb_gnt[PORT_B]) begin
          wren_d       = b_we;
          addr_d       = b_addr;
          data_d       = b_wdata;
          rd_d[PORT_B] = ~b_we;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Controller state and registered RAM command / grant outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt   <= '0;
      init_done <= 1'b0;
      a_gnt     <= 1'b0;
      b_gnt     <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= '0;
      ram_wren  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt   <= clr_cnt_d;
      init_done <= done_d;
      a_gnt     <= arb_gnt[PORT_A];
      b_gnt     <= arb_gnt[PORT_B];
      ram_addr  <= addr_d;
      ram_data  <= data_d;
      ram_wren  <= wren_d;
    end
  end

  // Read-valid pipe: p0 = command on bus, p1 = RAM captured it, then q is registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld_p0 <= 2'b00;
      rd_vld_p1 <= 2'b00;
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
      rdata     <= '0;
    end else begin
      rd_vld_p0 <= rd_d;
      rd_vld_p1 <= rd_vld_p0;
      a_rvalid  <= rd_vld_p1[PORT_A];
      b_rvalid  <= rd_vld_p1[PORT_B];
      if (|rd_vld_p1) begin
        rdata <= ram_q;
      end
    end
  end

endmodule

// File: tb/tb_ram32x4_arbiter.sv
// Randomised and directed bench for ram32x4_arbiter against a transaction-level model.
module tb_ram32x4_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clr_req = 1'b0;
  logic       init_done;
  logic       a_req, a_we, b_req, b_we;
  logic [4:0] a_addr, b_addr;
  logic [3:0] a_wdata, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [3:0] rdata, ram_data, ram_q;
  logic [4:0] ram_addr;
  logic       ram_wren;

  always #10 clk = ~clk;

  // Requester state: pending request per port (0 = A, 1 = B).
  bit         pend [2];
  bit         pwe  [2];
  logic [4:0] paddr[2];
  logic [3:0] pdata[2];

  assign a_req   = pend[0];
  assign a_we    = pwe[0];
  assign a_addr  = paddr[0];
  assign a_wdata = pdata[0];
  assign b_req   = pend[1];
  assign b_we    = pwe[1];
  assign b_addr  = paddr[1];
  assign b_wdata = pdata[1];

  ram32x4_arbiter dut (
    .clk(clk), .reset(reset), .clr_req(clr_req), .init_done(init_done),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid),
    .rdata(rdata), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_q(ram_q)
  );

  // Stand-in for ram32x4: inputs registered, q follows the registered address.
  logic [3:0] ram_mem [32];
  logic [4:0] ram_ra;
  always @(posedge clk) begin
    ram_ra <= ram_addr;
    if (ram_wren) ram_mem[ram_addr] <= ram_data;
  end
  assign ram_q = ram_mem[ram_ra];

  // Reference model: word contents, outstanding reads, clear progress.
  typedef struct {
    int         idx;
    logic [3:0] val;
    int         due;
  } rd_t;
  rd_t        rdq[$];
  logic [3:0] mem [32];
  int         clr_idx;
  bit         ptr;
  int         cyc;
  logic [1:0] e_gnt, e_rv;
  logic [3:0] e_rdata, e_data;
  logic [4:0] e_addr;
  logic       e_wren, e_done;
  int         n_chk, n_pass;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    clr_idx = 0; ptr = 1'b0;
    e_gnt = 2'b00; e_rv = 2'b00; e_rdata = 4'h0;
    e_wren = 1'b0; e_done = 1'b0; e_addr = 5'h0; e_data = 4'h0;
    rdq.delete();
    foreach (mem[i]) mem[i] = 4'h0;
  endtask

  // Predicts the outputs after the coming clock edge from the current inputs.
  task automatic model_edge();
    logic [1:0] el;
    int w;
    cyc++;
    if (reset) begin
      model_reset();
      return;
    end
    e_rv = 2'b00;
    for (int i = rdq.size() - 1; i >= 0; i--) begin
      if (rdq[i].due == cyc) begin
        e_rv[rdq[i].idx] = 1'b1;
        e_rdata = rdq[i].val;
        rdq.delete(i);
      end
    end
    el = {pend[1] && !e_gnt[1], pend[0] && !e_gnt[0]};
    e_gnt = 2'b00;
    e_wren = 1'b0;
    if (clr_idx >= 0) begin
      if (clr_idx == 32) begin
        clr_idx = -1;
        e_done = 1'b1;
      end else begin
        e_wren = 1'b1; e_addr = clr_idx[4:0]; e_data = 4'h0;
        clr_idx++;
      end
    end else if (clr_req) begin
      clr_idx = 0;
      e_done = 1'b0;
      foreach (mem[i]) mem[i] = 4'h0;
    end else if (el != 2'b00) begin
      if (el == 2'b11) begin
        w = int'(ptr);
        ptr = !ptr;
      end else begin
        w = el[1] ? 1 : 0;
      end
      e_gnt[w] = 1'b1;
      e_wren = pwe[w]; e_addr = paddr[w]; e_data = pdata[w];
      if (pwe[w]) mem[paddr[w]] = pdata[w];
      else rdq.push_back('{w, mem[paddr[w]], cyc + 2});
    end
  endtask

  task automatic compare();
    chk("init_done", init_done, e_done);
    chk("a_gnt", a_gnt, e_gnt[0]);
    chk("b_gnt", b_gnt, e_gnt[1]);
    chk("a_rvalid", a_rvalid, e_rv[0]);
    chk("b_rvalid", b_rvalid, e_rv[1]);
    if (e_rv != 2'b00) chk("rdata", rdata, e_rdata);
    chk("ram_wren", ram_wren, e_wren);
    chk("ram_addr", ram_addr, e_addr);
    chk("ram_data", ram_data, e_data);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare();
  endtask

  // One cycle with requesters dropping a request once its grant is seen.
  task automatic serve_step();
    step();
    if (a_gnt) pend[0] = 1'b0;
    if (b_gnt) pend[1] = 1'b0;
  endtask

  task automatic set_req(input int p, input bit we, input logic [4:0] ad, input logic [3:0] d);
    pend[p] = 1'b1; pwe[p] = we; paddr[p] = ad; pdata[p] = d;
  endtask

  task automatic txn(input int p, input bit we, input logic [4:0] ad, input logic [3:0] d,
                     output logic [3:0] got);
    bit seen;
    int k;
    got = 4'h0;
    set_req(p, we, ad, d);
    seen = 1'b0; k = 0;
    while (!seen && k < 100) begin
      serve_step();
      k++;
      seen = (p == 0) ? a_gnt : b_gnt;
    end
    chk("txn_gnt", seen, 1);
    if (!we) begin
      seen = 1'b0; k = 0;
      while (!seen && k < 6) begin
        serve_step();
        k++;
        if ((p == 0) ? a_rvalid : b_rvalid) begin
          seen = 1'b1;
          got = rdata;
        end
      end
      chk("txn_rvalid", seen, 1);
      chk("rd_latency", k, 2);
    end
  endtask

  task automatic wait_clear(input string tag);
    int n, wc;
    n = 0; wc = 0;
    while (!init_done && n < 40) begin
      serve_step();
      if (ram_wren) wc++;
      n++;
    end
    chk({tag, "_wren_cycles"}, wc, 32);
    chk({tag, "_done"}, init_done, 1);
  endtask

  task automatic hit_reset();
    reset = 1'b1;
    model_reset();
    pend[0] = 1'b0; pend[1] = 1'b0;
    #1;
    compare();
    chk("rst_rdata", rdata, 0);
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] got;
    int n, g, prev, first, ngr, gc;
    bit alt_ok, seen;
    n_chk = 0; n_pass = 0; cyc = 0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; pwe[p] = 1'b0; paddr[p] = 5'h0; pdata[p] = 4'h0;
    end
    model_reset();
    step();
    step();
    chk("rst_rdata", rdata, 0);
    reset = 1'b0;

    // Power-up wipe, then reads of cleared and written words.
    wait_clear("clr1");
    txn(0, 1'b0, 5'd5, 4'h0, got);
    chk("rd5_cleared", got, 4'h0);
    txn(0, 1'b1, 5'd0, 4'hA, got);
    txn(0, 1'b0, 5'd0, 4'h0, got);
    chk("rd0_written", got, 4'hA);

    // Simultaneous write by A and read by B of the same word.
    set_req(0, 1'b1, 5'h1F, 4'h5);
    set_req(1, 1'b0, 5'h1F, 4'h0);
    serve_step();
    chk("both_a_first", a_gnt, 1);
    chk("both_b_waits", b_gnt, 0);
    serve_step();
    chk("both_b_second", b_gnt, 1);
    serve_step();
    serve_step();
    chk("both_b_rvalid", b_rvalid, 1);
    chk("both_b_rdata", rdata, 4'h5);

    // Both ports hold requests continuously: grants must alternate.
    prev = -1; first = -1; ngr = 0; alt_ok = 1'b1; n = 0;
    while (ngr < 8 && n < 20) begin
      if (!pend[0]) set_req(0, 1'b0, 5'($urandom_range(0, 31)), 4'h0);
      if (!pend[1]) set_req(1, 1'b0, 5'($urandom_range(0, 31)), 4'h0);
      serve_step();
      n++;
      g = a_gnt ? 0 : (b_gnt ? 1 : -1);
      if (g >= 0) begin
        if (first < 0) first = g;
        if (g == prev) alt_ok = 1'b0;
        prev = g;
        ngr++;
      end
    end
    pend[0] = 1'b0; pend[1] = 1'b0;
    chk("alt_first_is_b", first, 1);
    chk("alt_strict", alt_ok, 1);
    chk("alt_count", ngr, 8);
    repeat (3) serve_step();

    // Clear on demand, with a read pending across the clear.
    txn(0, 1'b1, 5'd3, 4'h7, got);
    clr_req = 1'b1;
    set_req(0, 1'b0, 5'd3, 4'h0);
    serve_step();
    clr_req = 1'b0;
    chk("clr_edge_no_gnt", a_gnt, 0);
    chk("clr_edge_done_low", init_done, 0);
    n = 0; gc = 0;
    while (!init_done && n < 40) begin
      clr_req = (n == 10);
      serve_step();
      clr_req = 1'b0;
      if (a_gnt || b_gnt) gc++;
      n++;
    end
    chk("clear_no_grants", gc, 0);
    chk("clr2_done", init_done, 1);
    seen = 1'b0; n = 0; got = 4'hF;
    while (!seen && n < 10) begin
      serve_step();
      n++;
      if (a_rvalid) begin
        seen = 1'b1;
        got = rdata;
      end
    end
    chk("rd3_after_clr_valid", seen, 1);
    chk("rd3_after_clr", got, 4'h0);

    // Reset between a read grant and its rvalid.
    set_req(0, 1'b0, 5'd0, 4'h0);
    n = 0;
    while (!a_gnt && n < 10) begin
      serve_step();
      n++;
    end
    chk("midrd_gnt", a_gnt, 1);
    hit_reset();
    wait_clear("clr3");

    // Random traffic with occasional clears and one reset.
    for (int i = 0; i < 3000; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) == 0)
          set_req(p, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  4'($urandom_range(0, 15)));
      end
      clr_req = ($urandom_range(0, 199) == 0);
      if (i == 1500) begin
        clr_req = 1'b0;
        hit_reset();
      end else begin
        serve_step();
      end
      clr_req = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
